vend_panel_ctrl: RTL and testbench
==================================

Name: vend_panel_ctrl

Overview:
- Customer-side front panel for the coffee/tea vending machine controller; drives that controller's coin and user_in inputs and consumes its tea/coffee/coin_ret outputs.
- Debounces the raw coin-acceptor and button inputs, holds credit, and issues one selection per coin.
- Checks that the machine's response matches the request, with selection and response timeouts.
- Sits between the physical panel I/O and the vending controller.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a raw input change.
- SEL_TIMEOUT, 64: cycles in CREDIT without a selection before auto-cancel.
- RESP_TIMEOUT, 16: cycles in REQUEST without a machine response before FAULT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_raw  in  1  coin-acceptor contact, asynchronous, bouncy.
- btn_tea_raw  in  1  tea button, asynchronous.
- btn_coffee_raw  in  1  coffee button, asynchronous.
- btn_cancel_raw  in  1  cancel button, asynchronous.
- tea  in  1  machine dispensing tea.
- coffee  in  1  machine dispensing coffee.
- coin_ret  in  1  machine returning coin.
- coin  out  1  credit present, to machine.
- user_in  out  2  selection: 00 none, 01 tea, 10 coffee, 11 cancel/return.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a transaction completes correctly.
- fault  out  1  sticky error flag.
- coin_reject  out  1  one-cycle pulse when a coin event is ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE.
  - All outputs 0, user_in 00.
  - All counters and sync/debounce flops 0.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer's accepted level changes after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current accepted level.
  - A 0->1 change of the accepted level gives a one-cycle event.
  - Raw edge to event: 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Priority of simultaneous button events: cancel > coffee > tea.
- IDLE: coin=0, user_in=00. A coin event moves to CREDIT.
- CREDIT:
  - coin=1, user_in=00, selection counter running.
  - A selection event latches the code and moves to REQUEST on the next cycle.
  - Selection counter reaching SEL_TIMEOUT latches 11 and moves to REQUEST.
- REQUEST:
  - coin=1, user_in=latched code, response counter running.
  - Any of tea/coffee/coin_ret high ends the wait.
  - Expected response: tea for 01, coffee for 10, coin_ret for 11.
  - Exactly the expected signal high -> DONE.
  - Any other combination -> FAULT.
  - Response counter reaching RESP_TIMEOUT -> FAULT.
  - Button events are ignored.
- DONE:
  - coin=0, user_in=00.
  - done pulses on the entry cycle only.
  - Stay until tea, coffee and coin_ret are all low, then go to IDLE.
- FAULT:
  - coin=0, user_in=00, fault=1.
  - Leave only on a cancel event -> IDLE; fault clears on that transition.
- coin_reject: a coin event in any state other than IDLE pulses coin_reject for one cycle; state is unaffected.
- Counters:
  - Width is $clog2 of the parameter plus 1.
  - Counters clear on every state entry and saturate; no wrap-around.
- Reset asserted mid-transaction: immediate return to IDLE, coin and user_in drop the same instant, no done pulse.
- All outputs are registered.

Optional Feature:
- Macro: VEND_PANEL_VEND_COUNT_EN.
- Defined:
  - Adds output vend_count[7:0]: count of DONE entries with user_in 01 or 10.
  - Saturates at 255; reset to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - state enum: IDLE, CREDIT, REQUEST, DONE, FAULT.
  - selection constants: SEL_NONE=2'b00, SEL_TEA=2'b01, SEL_COFFEE=2'b10, SEL_CANCEL=2'b11.
- Sub-module vend_debounce: synchronizer, debouncer and rise-event generator, parameterized by DEBOUNCE_CYCLES. Instantiated four times.

Test Plan:
- Normal tea: coin_raw high 10 cycles, then btn_tea_raw high 10 cycles; model asserts tea 3 cycles after user_in=01.
  - coin rises 7 cycles after the coin_raw edge (6-cycle event latency + register).
  - user_in=01 follows the tea event.
  - done pulses once; back to IDLE after tea drops.
- Bounce rejection: coin_raw toggled every 2 cycles for 20 cycles, then low -> coin stays 0, state IDLE.
- Selection timeout: coin inserted, no button; model answers 11 with coin_ret -> user_in=11 exactly 64 cycles after CREDIT entry, then done.
- Wrong response: select coffee, model asserts tea -> fault=1, coin=0. Cancel press -> fault=0, IDLE.
- Response timeout and simultaneous buttons: tea and coffee pressed on the same cycle -> user_in=10. With no response, fault asserts 16 cycles after REQUEST entry. A second coin during REQUEST -> single coin_reject pulse.
- Mid-transaction reset: rst_n low during REQUEST -> coin/user_in 0 immediately, busy=0, no done. With VEND_PANEL_VEND_COUNT_EN defined, vend_count increments on tea and coffee but not on cancel.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending front panel: controller states, selection codes
// and the expected machine response for each selection.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CREDIT  = 3'd1,
        REQUEST = 3'd2,
        DONE    = 3'd3,
        FAULT   = 3'd4
    } state_e;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_TEA    = 2'b01;
    localparam logic [1:0] SEL_COFFEE = 2'b10;
    localparam logic [1:0] SEL_CANCEL = 2'b11;

    // Response vector is {tea, coffee, coin_ret}.
    function automatic logic [2:0] exp_resp(input logic [1:0] sel);
        logic [2:0] r;
        case (sel)
            SEL_TEA:    r = 3'b100;
            SEL_COFFEE: r = 3'b010;
            SEL_CANCEL: r = 3'b001;
            default:    r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vend_debounce.sv
// Two-flop synchronizer, counting debouncer and one-cycle rising-edge event
// for one raw panel contact.
module vend_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples disagreeing with the accepted level; flip on the Nth.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/vend_panel_ctrl.sv
// Vending machine front panel: conditions coin/button inputs, holds one credit,
// issues a selection and checks the machine's response.
// Optional VEND_PANEL_VEND_COUNT_EN adds a saturating count of tea/coffee vends.
module vend_panel_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SEL_TIMEOUT     = 64,
    parameter int unsigned RESP_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_raw,
    input  logic       btn_tea_raw,
    input  logic       btn_coffee_raw,
    input  logic       btn_cancel_raw,
    input  logic       tea,
    input  logic       coffee,
    input  logic       coin_ret,
    output logic       coin,
    output logic [1:0] user_in,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       coin_reject
`ifdef VEND_PANEL_VEND_COUNT_EN
    ,
    output logic [7:0] vend_count
`endif
);

    localparam int unsigned SEL_CW  = $clog2(SEL_TIMEOUT) + 1;
    localparam int unsigned RESP_CW = $clog2(RESP_TIMEOUT) + 1;

    logic coin_ev;
    logic tea_ev;
    logic coffee_ev;
    logic cancel_ev;

    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin (
        .clk(clk), .rst_n(rst_n), .raw_i(coin_raw), .rise_o(coin_ev)
    );
    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tea (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_tea_raw), .rise_o(tea_ev)
    );
    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coffee (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_coffee_raw), .rise_o(coffee_ev)
    );
    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_cancel_raw), .rise_o(cancel_ev)
    );

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [SEL_CW-1:0]  sel_cnt_q, sel_cnt_d;
    logic [RESP_CW-1:0] resp_cnt_q, resp_cnt_d;
    logic               coin_q, coin_d;
    logic [1:0]         user_in_q, user_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic               coin_reject_q, coin_reject_d;
    logic [2:0]         resp;

    assign resp = {tea, coffee, coin_ret};

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        sel_cnt_d     = '0;
        resp_cnt_d    = '0;
        coin_d        = 1'b0;
        user_in_d     = SEL_NONE;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        coin_reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_ev) state_d = CREDIT;
            end
            CREDIT: begin
                if (cancel_ev) begin
                    sel_d   = SEL_CANCEL;
                    state_d = REQUEST;
                end else if (coffee_ev) begin
                    sel_d   = SEL_COFFEE;
                    state_d = REQUEST;
                end else if (tea_ev) begin
                    sel_d   = SEL_TEA;
                    state_d = REQUEST;
                end else if (sel_cnt_q >= SEL_CW'(SEL_TIMEOUT - 1)) begin
                    sel_d   = SEL_CANCEL;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (|resp) begin
                    state_d = (resp == exp_resp(sel_q)) ? DONE : FAULT;
                end else if (resp_cnt_q >= RESP_CW'(RESP_TIMEOUT - 1)) begin
                    state_d = FAULT;
                end
            end
            DONE: begin
                if (resp == 3'b000) state_d = IDLE;
            end
            FAULT: begin
                if (cancel_ev) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counters run only while staying in their state, so any entry clears them.
        if (state_q == CREDIT && state_d == CREDIT && sel_cnt_q < SEL_CW'(SEL_TIMEOUT)) begin
            sel_cnt_d = sel_cnt_q + SEL_CW'(1);
        end else if (state_q == CREDIT && state_d == CREDIT) begin
            sel_cnt_d = sel_cnt_q;
        end
        if (state_q == REQUEST && state_d == REQUEST && resp_cnt_q < RESP_CW'(RESP_TIMEOUT)) begin
            resp_cnt_d = resp_cnt_q + RESP_CW'(1);
        end else if (state_q == REQUEST && state_d == REQUEST) begin
            resp_cnt_d = resp_cnt_q;
        end

        coin_d        = (state_d == CREDIT) || (state_d == REQUEST);
        user_in_d     = (state_d == REQUEST) ? sel_d : SEL_NONE;
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE) && (state_q != DONE);
        fault_d       = (state_d == FAULT);
        coin_reject_d = coin_ev && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= SEL_NONE;
            sel_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            coin_q        <= 1'b0;
            user_in_q     <= SEL_NONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            sel_cnt_q     <= sel_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            coin_q        <= coin_d;
            user_in_q     <= user_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign coin        = coin_q;
    assign user_in     = user_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign coin_reject = coin_reject_q;

`ifdef VEND_PANEL_VEND_COUNT_EN
    logic [7:0] vend_count_q;

    // Only real product vends count; cancel/return transactions do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vend_count_q <= 8'd0;
        end else if (done_d && (sel_q == SEL_TEA || sel_q == SEL_COFFEE) &&
                     vend_count_q != 8'hFF) begin
            vend_count_q <= vend_count_q + 8'd1;
        end
    end

    assign vend_count = vend_count_q;
`endif

endmodule

// File: tb/tb_vend_panel_ctrl.sv
// Directed self-checking bench for vend_panel_ctrl; the bench plays both the
// customer and the vending machine.
module tb_vend_panel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_raw, btn_tea_raw, btn_coffee_raw, btn_cancel_raw;
    logic       tea, coffee, coin_ret;
    logic       coin;
    logic [1:0] user_in;
    logic       busy, done, fault, coin_reject;
`ifdef VEND_PANEL_VEND_COUNT_EN
    logic [7:0] vend_count;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vend_panel_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .coin_raw(coin_raw), .btn_tea_raw(btn_tea_raw),
        .btn_coffee_raw(btn_coffee_raw), .btn_cancel_raw(btn_cancel_raw),
        .tea(tea), .coffee(coffee), .coin_ret(coin_ret),
        .coin(coin), .user_in(user_in), .busy(busy), .done(done),
        .fault(fault), .coin_reject(coin_reject)
`ifdef VEND_PANEL_VEND_COUNT_EN
        , .vend_count(vend_count)
`endif
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        coin_raw = 0; btn_tea_raw = 0; btn_coffee_raw = 0; btn_cancel_raw = 0;
        tea = 0; coffee = 0; coin_ret = 0;
        #23;
        checks++;
        if ({coin, user_in, busy, done, fault, coin_reject} !== 7'b0) begin
            $display("FAIL reset_outputs: got %b want %b",
                     {coin, user_in, busy, done, fault, coin_reject}, 7'b0);
            fails++;
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_idle: busy got %b want 0", busy); fails++;
        end
    endtask

    task automatic test_normal_tea;
        coin_raw = 1;
        tick(6);
        checks++;
        if (coin !== 1'b0) begin $display("FAIL tea_coin_early: got %b want 0", coin); fails++; end
        tick(1);
        checks++;
        if (coin !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL tea_coin_rise: coin %b busy %b want 1 1", coin, busy); fails++;
        end
        tick(3);
        coin_raw = 0; btn_tea_raw = 1;
        tick(6);
        checks++;
        if (user_in !== 2'b00) begin $display("FAIL tea_sel_early: got %b want 00", user_in); fails++; end
        tick(1);
        checks++;
        if (user_in !== 2'b01) begin $display("FAIL tea_sel: got %b want 01", user_in); fails++; end
        tick(3);
        btn_tea_raw = 0; tea = 1;
        tick(1);
        checks++;
        if (done !== 1'b1 || coin !== 1'b0 || user_in !== 2'b00) begin
            $display("FAIL tea_done: done %b coin %b user_in %b want 1 0 00", done, coin, user_in); fails++;
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL tea_done_pulse: done %b busy %b want 0 1", done, busy); fails++;
        end
        tea = 0;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin $display("FAIL tea_idle: busy got %b want 0", busy); fails++; end
        tick(10);
    endtask

    task automatic test_bounce;
        logic seen_coin;
        seen_coin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            coin_raw = ~coin_raw;
            tick(1); seen_coin |= coin | busy;
            tick(1); seen_coin |= coin | busy;
        end
        coin_raw = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1); seen_coin |= coin | busy;
        end
        checks++;
        if (seen_coin !== 1'b0) begin
            $display("FAIL bounce_reject: coin/busy seen %b want 0", seen_coin); fails++;
        end
    endtask

    task automatic test_sel_timeout;
        coin_raw = 1;
        tick(7);
        coin_raw = 0;
        tick(63);
        checks++;
        if (user_in !== 2'b00 || coin !== 1'b1) begin
            $display("FAIL tmo_sel_early: user_in %b coin %b want 00 1", user_in, coin); fails++;
        end
        tick(1);
        checks++;
        if (user_in !== 2'b11) begin $display("FAIL tmo_sel: got %b want 11", user_in); fails++; end
        coin_ret = 1;
        tick(1);
        checks++;
        if (done !== 1'b1) begin $display("FAIL tmo_done: got %b want 1", done); fails++; end
        coin_ret = 0;
        tick(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL tmo_idle: busy %b done %b want 0 0", busy, done); fails++;
        end
        tick(10);
    endtask

    task automatic test_wrong_resp;
        coin_raw = 1;
        tick(7);
        coin_raw = 0; btn_coffee_raw = 1;
        tick(7);
        checks++;
        if (user_in !== 2'b10) begin $display("FAIL wrong_sel: got %b want 10", user_in); fails++; end
        btn_coffee_raw = 0; tea = 1;
        tick(1);
        checks++;
        if (fault !== 1'b1 || coin !== 1'b0 || done !== 1'b0) begin
            $display("FAIL wrong_fault: fault %b coin %b done %b want 1 0 0", fault, coin, done); fails++;
        end
        tea = 0;
        tick(3);
        checks++;
        if (fault !== 1'b1) begin $display("FAIL wrong_sticky: got %b want 1", fault); fails++; end
        btn_cancel_raw = 1;
        tick(6);
        checks++;
        if (fault !== 1'b1) begin $display("FAIL wrong_cancel_early: got %b want 1", fault); fails++; end
        tick(1);
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL wrong_clear: fault %b busy %b want 0 0", fault, busy); fails++;
        end
        btn_cancel_raw = 0;
        tick(10);
    endtask

    task automatic test_resp_timeout;
        coin_raw = 1;
        tick(7);
        coin_raw = 0; btn_tea_raw = 1; btn_coffee_raw = 1;
        tick(7);
        checks++;
        if (user_in !== 2'b10) begin $display("FAIL simul_sel: got %b want 10", user_in); fails++; end
        btn_tea_raw = 0; btn_coffee_raw = 0;
        tick(1);
        coin_raw = 1;
        tick(6);
        checks++;
        if (coin_reject !== 1'b0) begin $display("FAIL reject_early: got %b want 0", coin_reject); fails++; end
        tick(1);
        checks++;
        if (coin_reject !== 1'b1) begin $display("FAIL reject_pulse: got %b want 1", coin_reject); fails++; end
        tick(1);
        checks++;
        if (coin_reject !== 1'b0 || user_in !== 2'b10) begin
            $display("FAIL reject_once: reject %b user_in %b want 0 10", coin_reject, user_in); fails++;
        end
        coin_raw = 0;
        tick(6);
        checks++;
        if (fault !== 1'b0) begin $display("FAIL resp_tmo_early: got %b want 0", fault); fails++; end
        tick(1);
        checks++;
        if (fault !== 1'b1 || coin !== 1'b0) begin
            $display("FAIL resp_tmo: fault %b coin %b want 1 0", fault, coin); fails++;
        end
        btn_cancel_raw = 1;
        tick(7);
        checks++;
        if (fault !== 1'b0) begin $display("FAIL resp_tmo_clear: got %b want 0", fault); fails++; end
        btn_cancel_raw = 0;
        tick(10);
    endtask

    task automatic test_vend_count;
`ifdef VEND_PANEL_VEND_COUNT_EN
        checks++;
        if (vend_count !== 8'd1) begin $display("FAIL count_tea_only: got %0d want 1", vend_count); fails++; end
        coin_raw = 1;
        tick(7);
        coin_raw = 0; btn_coffee_raw = 1;
        tick(7);
        btn_coffee_raw = 0;
        tick(1);
        coffee = 1;
        tick(1);
        checks++;
        if (done !== 1'b1 || vend_count !== 8'd2) begin
            $display("FAIL count_coffee: done %b count %0d want 1 2", done, vend_count); fails++;
        end
        coffee = 0;
        tick(10);
`endif
    endtask

    task automatic test_mid_reset;
        coin_raw = 1;
        tick(7);
        coin_raw = 0; btn_tea_raw = 1;
        tick(7);
        checks++;
        if (coin !== 1'b1 || user_in !== 2'b01) begin
            $display("FAIL mid_req: coin %b user_in %b want 1 01", coin, user_in); fails++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (coin !== 1'b0 || user_in !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL mid_reset: coin %b user_in %b busy %b done %b want 0 00 0 0",
                     coin, user_in, busy, done); fails++;
        end
`ifdef VEND_PANEL_VEND_COUNT_EN
        checks++;
        if (vend_count !== 8'd0) begin $display("FAIL mid_reset_count: got %0d want 0", vend_count); fails++; end
`endif
        btn_tea_raw = 0;
        tick(3);
        #2;
        rst_n = 1'b1;
        tick(10);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || coin !== 1'b0) begin
            $display("FAIL post_reset: busy %b done %b coin %b want 0 0 0", busy, done, coin); fails++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_tea();
        test_bounce();
        test_sel_timeout();
        test_wrong_resp();
        test_resp_timeout();
        test_vend_count();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
